sram_bank_allocator: RTL
========================

// Module: sram_bank_allocator
// PURPOSE
//   Central allocator for the dynamic shared cache. NUM_REQ requesters each ask for one
//   SRAM bank out of a NUM_BANK pool. The block arbitrates round-robin, assigns the
//   lowest-index free bank, tracks ownership and returns banks on free_req. It is the
//   controller that drives alloc_valid/sram_id into the per-bank bitmap instances.
// PARAMETERS
//   NUM_REQ    16                       number of requesters
//   NUM_BANK   32                       number of SRAM banks in the pool
//   BANK_ID_W  $clog2(NUM_BANK)         bank id width (5)
//   CNT_W      $clog2(NUM_BANK+1)       free-count width (6)
// PORTS
//   clk          in   1          clock
//   rst_n        in   1          reset, asynchronous, active-high
//   alloc_req    in   NUM_REQ    level request per requester; held until alloc_gnt
//   free_req     in   NUM_REQ    1-cycle pulse: release the bank owned by requester i
//   alloc_gnt    out  NUM_REQ    one-hot, 1-cycle grant pulse
//   gnt_bank_id  out  BANK_ID_W  bank assigned; valid only while |alloc_gnt
//   alloc_valid  out  1          = |alloc_gnt; strobe to bitmap instances
//   free_bitmap  out  NUM_BANK   bit b = 1 -> bank b free
//   owner_valid  out  NUM_REQ    bit i = 1 -> requester i currently owns a bank
//   free_count   out  CNT_W      popcount of free_bitmap
//   err_free     out  1          1-cycle pulse: free_req from requester owning no bank
// BEHAVIOUR
//   Reset (rst_n=1, async): state IDLE, free_bitmap all 1s, free_count=NUM_BANK,
//     owner_valid=0, alloc_gnt=0, gnt_bank_id=0, alloc_valid=0, err_free=0, rr_ptr=0.
//   Eligible set: alloc_req & ~owner_valid & ~free_req.
//   FSM IDLE -> GRANT -> IDLE:
//     IDLE: if eligible!=0 and free_count!=0: latch winner = first eligible index at or
//       after rr_ptr (wrap NUM_REQ-1 -> 0); go GRANT. Else stay IDLE, rr_ptr unchanged.
//     GRANT: bank = lowest set bit of free_bitmap; clear it, owner_id[winner]=bank,
//       owner_valid[winner]=1, registered alloc_gnt[winner]=1 and gnt_bank_id=bank for the
//       following cycle; rr_ptr = (winner+1) mod NUM_REQ; go IDLE.
//   Latency: request sampled at edge E0 -> grant visible in the cycle after E1 (2 edges).
//   Throughput: at most one grant per 2 cycles.
//   Free: at each edge, every i with free_req[i] & owner_valid[i] sets
//     free_bitmap[owner_id[i]] and clears owner_valid[i]; multiple frees in one cycle all
//     applied. free_req[i] & ~owner_valid[i] -> err_free pulse next cycle, no state change.
//   Simultaneous free and GRANT in the same cycle: grant uses the pre-free bitmap; freed
//     bank becomes allocatable from the next arbitration. Winner latched in IDLE is never
//     the freeing requester (masked), so owner update and free never hit the same index.
//   Pool empty: no arbitration; requests wait, no error. free_count never underflows.
//   Requester already owning a bank and holding alloc_req: masked, never double-granted.
//   Reset mid-GRANT: grant aborted, no alloc_gnt pulse, all banks return free.
//   Invariant: popcount(free_bitmap) + popcount(owner_valid) == NUM_BANK.
// STRUCTURE
//   Package sram_alloc_pkg: NUM_REQ/NUM_BANK defaults, BANK_ID_W, CNT_W, typedef
//     bank_id_t, req_vec_t, bank_vec_t, enum alloc_state_e {IDLE, GRANT}.
//   Sub-module rr_arbiter (NUM_REQ, req vector + rr_ptr -> winner index + found flag),
//     combinational. Lowest-free-bank priority encoder, owner table and FSM stay inline.
// TESTING
//   1 Reset: hold rst_n=1 5 cycles -> free_bitmap=32'hFFFF_FFFF, free_count=32,
//     owner_valid=0, alloc_gnt=0; assert rst_n mid-GRANT -> no gnt pulse.
//   2 Single request: alloc_req[3]=1 -> alloc_gnt=16'h0008, gnt_bank_id=0 two edges later,
//     free_bitmap[0]=0, free_count=31, owner_valid[3]=1.
//   3 All 16 request together, held 5+ cycles, dropped on grant -> grants 0,1,...,15 one
//     every 2 cycles, bank ids 0..15, free_count ends at 16.
//   4 Round robin: after grant to 5, reqs 2 and 7 -> 7 granted first, then 2.
//   5 Exhaustion (NUM_BANK=4): requesters 0..4 request -> 0..3 get banks 0..3, 4 waits;
//     free_req[1] -> bank 1 free next cycle, requester 4 then gets bank 1.
//   6 Error/overlap: free_req[9] with owner_valid[9]=0 -> err_free pulse, bitmap unchanged;
//     free_req[2] during GRANT of requester 6 -> 6 gets lowest pre-free bank, invariant holds.

Source files
------------

// File: rtl/sram_alloc_pkg.sv
// Shared constants, types and FSM states for the SRAM bank allocator.
package sram_alloc_pkg;

   localparam int NUM_REQ_DEF  = 16;
   localparam int NUM_BANK_DEF = 32;
   localparam int BANK_ID_W    = $clog2(NUM_BANK_DEF);
   localparam int CNT_W        = $clog2(NUM_BANK_DEF + 1);

   typedef logic [BANK_ID_W-1:0]    bank_id_t;
   typedef logic [NUM_REQ_DEF-1:0]  req_vec_t;
   typedef logic [NUM_BANK_DEF-1:0] bank_vec_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping to index 0.
module rr_arbiter #(
   parameter int NUM_REQ = 16,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               found
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] sel;

   // Walk the requesters starting at the pointer and keep the first hit.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      sel    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
         end
         sel = sum[PTR_W-1:0];
         if (!found && req[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
   end

endmodule

// File: rtl/sram_bank_allocator.sv
// Hands out SRAM banks to requesters round-robin, tracks owners and takes banks back.
module sram_bank_allocator
   import sram_alloc_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int NUM_BANK  = NUM_BANK_DEF,
   parameter int BANK_ID_W = $clog2(NUM_BANK),
   parameter int CNT_W     = $clog2(NUM_BANK + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   alloc_req,
   input  logic [NUM_REQ-1:0]   free_req,
   output logic [NUM_REQ-1:0]   alloc_gnt,
   output logic [BANK_ID_W-1:0] gnt_bank_id,
   output logic                 alloc_valid,
   output logic [NUM_BANK-1:0]  free_bitmap,
   output logic [NUM_REQ-1:0]   owner_valid,
   output logic [CNT_W-1:0]     free_count,
   output logic                 err_free
);

   localparam int REQ_ID_W = $clog2(NUM_REQ);

   alloc_state_e          state;
   logic [REQ_ID_W-1:0]   rr_ptr;
   logic [REQ_ID_W-1:0]   winner;
   logic [BANK_ID_W-1:0]  owner_id [NUM_REQ];

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    free_hits;
   logic [REQ_ID_W-1:0]   arb_winner;
   logic                  arb_found;
   logic [BANK_ID_W-1:0]  low_bank;
   logic [NUM_BANK-1:0]   bitmap_next;
   logic [NUM_REQ-1:0]    owner_next;

   // Owners and requesters freeing this cycle never compete for a new bank.
   assign eligible  = alloc_req & ~owner_valid & ~free_req;
   assign free_hits = free_req & owner_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (REQ_ID_W)
   ) u_arb (
      .req    (eligible),
      .rr_ptr (rr_ptr),
      .winner (arb_winner),
      .found  (arb_found)
   );

   // Lowest-index free bank, scanning high to low so the last hit wins.
   always_comb begin
      low_bank = '0;
      for (int b = NUM_BANK - 1; b >= 0; b--) begin
         if (free_bitmap[b]) begin
            low_bank = BANK_ID_W'(b);
         end
      end
   end

   // Free-bank count straight from the bitmap, so it can never underflow.
   always_comb begin
      free_count = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
         free_count = free_count + CNT_W'(free_bitmap[b]);
      end
   end

   // Next bitmap/ownership: the grant claims a bank from the pre-free bitmap, then frees apply.
   always_comb begin
      bitmap_next = free_bitmap;
      owner_next  = owner_valid;
      if (state == GRANT) begin
         bitmap_next[low_bank] = 1'b0;
         owner_next[winner]    = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (free_hits[i]) begin
            bitmap_next[owner_id[i]] = 1'b1;
            owner_next[i]            = 1'b0;
         end
      end
   end

   // Allocation FSM with registered grant, ownership and error outputs.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         winner      <= '0;
         alloc_gnt   <= '0;
         gnt_bank_id <= '0;
         alloc_valid <= 1'b0;
         err_free    <= 1'b0;
         free_bitmap <= '1;
         owner_valid <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            owner_id[i] <= '0;
         end
      end else begin
         free_bitmap <= bitmap_next;
         owner_valid <= owner_next;
         err_free    <= |(free_req & ~owner_valid);
         alloc_gnt   <= '0;
         alloc_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found && (free_count != '0)) begin
                  winner <= arb_winner;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               owner_id[winner]  <= low_bank;
               alloc_gnt[winner] <= 1'b1;
               alloc_valid       <= 1'b1;
               gnt_bank_id       <= low_bank;
               rr_ptr            <= (winner == REQ_ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
